// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier.
// Holds the control state encoding and the default operand width.
package mult_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/abs_val.sv
// Two's-complement magnitude of a WIDTH-bit value.
// With enable low the value passes through unchanged (unsigned mode).
module abs_val #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
  output logic [WIDTH-1:0] magnitude
);

  logic neg;

  // Negate only negative signed operands; the most negative value
  // maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  always_comb begin
    neg = enable & value[WIDTH-1];
    magnitude = neg ? (~value + 1'b1) : value;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned,
// with valid/ready handshakes on both operand and product sides.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               sign;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] result;
  logic               last;
  logic               take;

  abs_val #(
    .WIDTH (WIDTH)
  ) u_abs_a (
    .value     (a),
    .enable    (signed_mode),
    .magnitude (a_mag)
  );

  abs_val #(
    .WIDTH (WIDTH)
  ) u_abs_b (
    .value     (b),
    .enable    (signed_mode),
    .magnitude (b_mag)
  );

  // One shift-add step: add multiplicand into the upper half
  // (carry kept in sum[WIDTH]), then shift the whole thing right.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
        + (mplier[0] ? {1'b0, mcand} : '0);
    acc_step = {sum, acc[WIDTH-1:1]};
    result = sign ? (~acc_step + 1'b1) : acc_step;
    last = (cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    take       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        take     = in_valid;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands, iterate, publish the product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      sign   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      p      <= '0;
    end else begin
      if (take) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        sign   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        cnt    <= '0;
        acc    <= '0;
      end else if (state == BUSY) begin
        acc    <= acc_step;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) p <= result;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and randomized checks of shift_add_multiplier at WIDTH=8.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;

  int checks;
  int failures;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic           sm;
    logic [2*W-1:0] ex;
    string          name;
  } vec_t;

  vec_t vecs [9];

  shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic sm);
    int ix;
    int iy;
    int pr;
    ix = sm ? int'($signed(x)) : int'(x);
    iy = sm ? int'($signed(y)) : int'(y);
    pr = ix * iy;
    return pr[2*W-1:0];
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("wait_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Full operation: capture, latency, hold under backpressure, handshake.
  task automatic run_op(input logic [W-1:0] ia,
                        input logic [W-1:0] ib,
                        input logic ism,
                        input logic [2*W-1:0] ex,
                        input int hold,
                        input string name);
    int n;
    wait_ready();
    a = ia;
    b = ib;
    signed_mode = ism;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    signed_mode = ~ism;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd8);
    check({name, "_p"}, 32'(p), 32'(ex));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_p"}, 32'(p), 32'(ex));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({name, "_p_retained"}, 32'(p), 32'(ex));
  endtask

  initial begin
    int n;
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F, "u13x11"};
    vecs[1] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01, "u255x255"};
    vecs[2] = '{8'h80,  8'h80,  1'b1, 16'h4000, "s_m128xm128"};
    vecs[3] = '{8'hFF,  8'h01,  1'b1, 16'hFFFF, "s_m1x1"};
    vecs[4] = '{8'h00,  8'hFB,  1'b1, 16'h0000, "s_0xm5"};
    vecs[5] = '{8'h80,  8'h7F,  1'b1, 16'hC080, "s_m128x127"};
    vecs[6] = '{8'hFF,  8'hFF,  1'b1, 16'h0001, "s_m1xm1"};
    vecs[7] = '{8'h80,  8'h02,  1'b0, 16'h0100, "u128x2"};
    vecs[8] = '{8'h00,  8'h00,  1'b0, 16'h0000, "u0x0"};

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].va, vecs[i].vb, vecs[i].sm, vecs[i].ex, 0,
             vecs[i].name);

    // Backpressure: product held for 5 cycles.
    run_op(8'd7, 8'd9, 1'b0, 16'h003F, 5, "bp7x9");

    // in_valid held high through BUSY/DONE with changing operands.
    wait_ready();
    a = 8'd3;
    b = 8'd4;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 40) begin
      check("ign_in_ready_busy", 32'(in_ready), 32'd0);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      n++;
    end
    check("ign_latency", 32'(n), 32'd8);
    check("ign_p", 32'(p), 32'd12);
    a = 8'd5;
    b = 8'd6;
    @(negedge clk);
    check("ign_p_done_hold", 32'(p), 32'd12);
    check("ign_no_accept_in_done", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ign_idle_after_hs", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("ign_next_captured", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ign_next_latency", 32'(n), 32'd8);
    check("ign_next_p", 32'(p), 32'd30);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in BUSY cycle 4 aborts the operation.
    wait_ready();
    a = 8'd13;
    b = 8'd11;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_p", 32'(p), 32'd0);
    rst_n = 1'b1;
    a = 8'd3;
    b = 8'd5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_accept", 32'(in_ready), 32'd0);
    n = 0;
    seen = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_latency", 32'(n), 32'd8);
    check("post_rst_p", 32'(p), 32'h000F);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while a product is held in DONE.
    wait_ready();
    a = 8'd9;
    b = 8'd9;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("done_held_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("done_rst_valid", 32'(out_valid), 32'd0);
    check("done_rst_p", 32'(p), 32'd0);
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("done_rst_no_output", 32'(seen), 32'd0);

    // Random sweep against the behavioural reference.
    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, ref_mul(ra, rb, rs), $urandom_range(0, 3),
             "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
